// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronizes and debounces the front-panel inputs and sequences
// IDLE/RUN/PAUSE/ADJUST, generating count, adjust, clear and blink strobes.
//
// state  | meaning
// IDLE   | cleared, waiting for first pause press
// RUN    | counting, count_en every TICK_DIV cycles
// PAUSE  | holding, partial second retained
// ADJUST | field edit, adj_en and blink every ADJ_DIV cycles
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 100000000,
    parameter int ADJ_DIV   = 50000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_clr,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic       paused,
    output logic       count_en,
    output logic       adj_en,
    output logic       adj_sel,
    output logic       clr,
    output logic       blink,
    output logic [1:0] state
);
    localparam int DIV_MAX = (TICK_DIV > ADJ_DIV) ? TICK_DIV : ADJ_DIV;
    localparam int PW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int DW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_TC = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] ADJ_TC  = PW'(ADJ_DIV - 1);
    localparam logic [DW-1:0] DB_TC   = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSE  = 2'd2,
        S_ADJUST = 2'd3
    } state_t;

    // bit 0 = pause, 1 = clear, 2 = adjust switch, 3 = field select
    logic [3:0]    sync1, sync2;
    logic [2:0]    db_lvl;
    logic [1:0]    db_lvl_d;
    logic [DW-1:0] db_cnt [3];
    logic [1:0]    blocked;
    logic [1:0]    settle;
    logic          rst_d;
    logic [1:0]    press;
    logic          pause_press, adj_lvl;

    state_t        state_q, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          blink_q, blink_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            db_lvl   <= '0;
            db_lvl_d <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
            blocked  <= 2'b11;
            settle   <= '0;
            rst_d    <= 1'b1;
            adj_sel  <= 1'b0;
        end else begin
            sync1    <= {sw_sel, sw_adj, btn_clr, btn_pause};
            sync2    <= sync1;
            db_lvl_d <= db_lvl[1:0];
            rst_d    <= 1'b0;
            adj_sel  <= sync2[3];
            if (settle != 2'd2) settle <= settle + 2'd1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_TC) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
            // A button held through reset stays blocked until it is seen released
            // once the synchronizer has flushed its reset zeros.
            for (int i = 0; i < 2; i++) begin
                if (settle == 2'd2 && !sync2[i] && !db_lvl[i]) blocked[i] <= 1'b0;
            end
        end
    end

    assign press       = db_lvl[1:0] & ~db_lvl_d & ~blocked;
    assign pause_press = press[0];
    assign adj_lvl     = db_lvl[2];
    assign clr         = press[1] | rst_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc   <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            presc   <= presc_nxt;
            blink_q <= blink_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        presc_nxt = presc;
        blink_nxt = blink_q;
        count_en  = (state_q == S_RUN) && (presc == TICK_TC) && !clr;
        adj_en    = (state_q == S_ADJUST) && (presc == ADJ_TC) && !clr;
        if (clr) begin
            state_nxt = S_IDLE;
            presc_nxt = '0;
            blink_nxt = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    presc_nxt = '0;
                    if (pause_press)  state_nxt = S_RUN;
                    else if (adj_lvl) state_nxt = S_ADJUST;
                end
                S_RUN: begin
                    if (pause_press) begin
                        // keep the partial second, but a completed one must not recount
                        state_nxt = S_PAUSE;
                        if (presc == TICK_TC) presc_nxt = '0;
                    end else begin
                        presc_nxt = (presc == TICK_TC) ? '0 : presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (pause_press) begin
                        state_nxt = S_RUN;
                    end else if (adj_lvl) begin
                        state_nxt = S_ADJUST;
                        presc_nxt = '0;
                    end
                end
                S_ADJUST: begin
                    if (!adj_lvl) begin
                        state_nxt = S_PAUSE;
                        presc_nxt = '0;
                        blink_nxt = 1'b0;
                    end else if (presc == ADJ_TC) begin
                        presc_nxt = '0;
                        blink_nxt = ~blink_q;
                    end else begin
                        presc_nxt = presc + PW'(1);
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign state  = state_q;
    assign paused = (state_q != S_RUN);
    assign blink  = blink_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, ADJ_DIV=3, DB_CYCLES=2;
// outputs are sampled 1 ns after each rising edge.
module tb_stopwatch_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_pause = 1'b0, btn_clr = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
    logic       paused, count_en, adj_en, adj_sel, clr, blink;
    logic [1:0] state;
    int         total = 0;
    int         bad = 0;

    stopwatch_ctrl #(.TICK_DIV(4), .ADJ_DIV(3), .DB_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .btn_pause(btn_pause), .btn_clr(btn_clr),
        .sw_adj(sw_adj), .sw_sel(sw_sel), .paused(paused), .count_en(count_en),
        .adj_en(adj_en), .adj_sel(adj_sel), .clr(clr), .blink(blink), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Debounced pause press: the state changes on the 5th tick.
    task automatic press_pause();
        btn_pause = 1'b1;
        repeat (6) tick();
        btn_pause = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total += 7;
        if (state !== 2'd0)   begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
        if (paused !== 1'b1)  begin bad++; $display("FAIL rst_paused got=%b want=1", paused); end
        if (count_en !== 1'b0) begin bad++; $display("FAIL rst_count_en got=%b want=0", count_en); end
        if (adj_en !== 1'b0)  begin bad++; $display("FAIL rst_adj_en got=%b want=0", adj_en); end
        if (clr !== 1'b1)     begin bad++; $display("FAIL rst_clr got=%b want=1", clr); end
        if (blink !== 1'b0)   begin bad++; $display("FAIL rst_blink got=%b want=0", blink); end
        if (adj_sel !== 1'b0) begin bad++; $display("FAIL rst_adj_sel got=%b want=0", adj_sel); end
        rst = 1'b0;
        tick();
        total++;
        if (clr !== 1'b0) begin bad++; $display("FAIL rst_clr_drop got=%b want=0", clr); end
        tick();
        tick();
    endtask

    task automatic test_start();
        int n = 0;
        btn_pause = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) btn_pause = 1'b0;
            if (count_en) n++;
            total += 3;
            if (state !== ((i >= 5) ? 2'd1 : 2'd0))
                begin bad++; $display("FAIL start_state i=%0d got=%0d want=%0d", i, state, (i >= 5) ? 1 : 0); end
            if (paused !== (i < 5))
                begin bad++; $display("FAIL start_paused i=%0d got=%b want=%b", i, paused, i < 5); end
            if (count_en !== (i >= 8 && i % 4 == 0))
                begin bad++; $display("FAIL start_count_en i=%0d got=%b want=%b", i, count_en, i >= 8 && i % 4 == 0); end
        end
        total++;
        if (n != 4) begin bad++; $display("FAIL start_count_total got=%0d want=4", n); end
    endtask

    task automatic test_pause_resume();
        int  n = 0;
        bit  found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (count_en) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL pr_sync count_en got=0 want=1"); end
        repeat (3) tick();
        btn_pause = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 6) btn_pause = 1'b0;
            if (count_en) n++;
            if (j == 4) begin
                total++;
                if (state !== 2'd1) begin bad++; $display("FAIL pr_before state got=%0d want=1", state); end
            end
            if (j >= 5) begin
                total += 3;
                if (state !== 2'd2)    begin bad++; $display("FAIL pr_paused_state j=%0d got=%0d want=2", j, state); end
                if (count_en !== 1'b0) begin bad++; $display("FAIL pr_paused_count j=%0d got=%b want=0", j, count_en); end
                if (paused !== 1'b1)   begin bad++; $display("FAIL pr_paused_flag j=%0d got=%b want=1", j, paused); end
            end
        end
        total++;
        if (n != 1) begin bad++; $display("FAIL pr_count_total got=%0d want=1", n); end
        btn_pause = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) begin
                total += 2;
                if (state !== 2'd1)    begin bad++; $display("FAIL pr_resume_state got=%0d want=1", state); end
                if (count_en !== 1'b0) begin bad++; $display("FAIL pr_resume_early got=%b want=0", count_en); end
            end
            if (k == 6) begin
                total++;
                if (count_en !== 1'b1) begin bad++; $display("FAIL pr_resume_count got=%b want=1", count_en); end
            end
        end
        btn_pause = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_adjust();
        bit exp_blink, exp_adj;
        press_pause();
        total++;
        if (state !== 2'd2) begin bad++; $display("FAIL adj_pre state got=%0d want=2", state); end
        sw_adj = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            tick();
            if (j == 14) sw_sel = 1'b1;
            exp_adj   = (j >= 7) && ((j - 7) % 3 == 0);
            exp_blink = (j >= 5) ? (((j - 5) / 3) % 2 == 1) : 1'b0;
            total += 3;
            if (state !== ((j >= 5) ? 2'd3 : 2'd2))
                begin bad++; $display("FAIL adj_state j=%0d got=%0d want=%0d", j, state, (j >= 5) ? 3 : 2); end
            if (adj_en !== exp_adj)
                begin bad++; $display("FAIL adj_en j=%0d got=%b want=%b", j, adj_en, exp_adj); end
            if (blink !== exp_blink)
                begin bad++; $display("FAIL adj_blink j=%0d got=%b want=%b", j, blink, exp_blink); end
            if (j == 16) begin
                total++;
                if (adj_sel !== 1'b0) begin bad++; $display("FAIL adj_sel_early got=%b want=0", adj_sel); end
            end
            if (j == 17) begin
                total++;
                if (adj_sel !== 1'b1) begin bad++; $display("FAIL adj_sel got=%b want=1", adj_sel); end
            end
        end
    endtask

    task automatic test_adjust_exit();
        btn_pause = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 6) btn_pause = 1'b0;
            total++;
            if (state !== 2'd3) begin bad++; $display("FAIL adjx_ignore j=%0d got=%0d want=3", j, state); end
        end
        sw_adj = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            tick();
            if (j >= 5) begin
                total += 3;
                if (state !== 2'd2)  begin bad++; $display("FAIL adjx_state j=%0d got=%0d want=2", j, state); end
                if (blink !== 1'b0)  begin bad++; $display("FAIL adjx_blink j=%0d got=%b want=0", j, blink); end
                if (adj_en !== 1'b0) begin bad++; $display("FAIL adjx_adj_en j=%0d got=%b want=0", j, adj_en); end
            end
        end
        sw_sel = 1'b0;
    endtask

    task automatic test_clear_priority();
        bit found = 0;
        press_pause();
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL clr_pre state got=%0d want=1", state); end
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (count_en) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL clr_sync count_en got=0 want=1"); end
        btn_clr   = 1'b1;
        btn_pause = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (j == 6) begin btn_clr = 1'b0; btn_pause = 1'b0; end
            if (j == 3) begin
                total++;
                if (clr !== 1'b0) begin bad++; $display("FAIL clr_early got=%b want=0", clr); end
            end
            if (j == 4) begin
                total += 3;
                if (clr !== 1'b1)      begin bad++; $display("FAIL clr_pulse got=%b want=1", clr); end
                if (count_en !== 1'b0) begin bad++; $display("FAIL clr_count_en got=%b want=0", count_en); end
                if (adj_en !== 1'b0)   begin bad++; $display("FAIL clr_adj_en got=%b want=0", adj_en); end
            end
            if (j >= 5) begin
                total += 2;
                if (clr !== 1'b0)   begin bad++; $display("FAIL clr_once j=%0d got=%b want=0", j, clr); end
                if (state !== 2'd0) begin bad++; $display("FAIL clr_state j=%0d got=%0d want=0", j, state); end
            end
        end
        repeat (6) tick();
        total++;
        if (state !== 2'd0) begin bad++; $display("FAIL clr_hold state got=%0d want=0", state); end
        btn_pause = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) btn_pause = 1'b0;
            if (k == 5) begin
                total++;
                if (state !== 2'd1) begin bad++; $display("FAIL clr_restart state got=%0d want=1", state); end
            end
            if (k >= 5) begin
                total++;
                if (count_en !== (k == 8))
                    begin bad++; $display("FAIL clr_presc_zero k=%0d got=%b want=%b", k, count_en, k == 8); end
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_glitch();
        btn_pause = 1'b1;
        tick();
        btn_pause = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            total++;
            if (state !== 2'd1) begin bad++; $display("FAIL glitch_state j=%0d got=%0d want=1", j, state); end
        end
    endtask

    task automatic test_reset_held();
        btn_pause = 1'b1;
        rst = 1'b1;
        tick();
        total += 3;
        if (state !== 2'd0)    begin bad++; $display("FAIL rsth_state got=%0d want=0", state); end
        if (clr !== 1'b1)      begin bad++; $display("FAIL rsth_clr got=%b want=1", clr); end
        if (count_en !== 1'b0) begin bad++; $display("FAIL rsth_count_en got=%b want=0", count_en); end
        rst = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            total++;
            if (state !== 2'd0) begin bad++; $display("FAIL rsth_held j=%0d got=%0d want=0", j, state); end
        end
        btn_pause = 1'b0;
        repeat (6) tick();
        btn_pause = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) begin
                total++;
                if (state !== 2'd1) begin bad++; $display("FAIL rsth_repress got=%0d want=1", state); end
            end
        end
        btn_pause = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause_resume();
        test_adjust();
        test_adjust_exit();
        test_clear_priority();
        test_glitch();
        test_reset_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
